// File: rtl/pc_pkg.sv
// Shared types and defaults for the PC / fetch sequencing stage.
package pc_pkg;

    localparam int PC_W  = 12;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pc_state_t;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_ABS  = 2'd1,
        SEL_REL  = 2'd2,
        SEL_INC  = 2'd3
    } pc_sel_t;

endpackage

// File: rtl/pc_sat_counter.sv
// CW-bit up counter that sticks at all-ones; clear has priority over enable.
module pc_sat_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          en,
    output logic [CW-1:0] count
);

    // Count up while enabled, stop at the maximum value.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en && (count != {CW{1'b1}})) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch sequencer. Picks the next PC from halt / stall /
// LUT absolute jump / relative branch / increment and runs a start/done
// handshake around a RUN phase whose length is counted in cycle_count.
//
// Handshake: start is a single-cycle request that is only accepted in IDLE or
// DONE (ignored in RUN); acceptance is visible on the next cycle as busy=1.
// busy stays high until a halt is seen, after which done is held high until
// the next accepted start.
import pc_pkg::*;

module pc_fetch_ctrl #(
    parameter int D  = PC_W,
    parameter int CW = CNT_W
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          start,
    input  logic [D-1:0]  start_addr,
    input  logic          stall,
    input  logic          halt,
    input  logic          abs_jump,
    input  logic [3:0]    jump_idx,
    input  logic          rel_branch,
    input  logic [D-1:0]  rel_offset,
    output logic [2:0]    lut_addr,
    output logic          lut_third_bit,
    input  logic [D-1:0]  lut_target,
    output logic [D-1:0]  prog_ctr,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cycle_count,
    output logic          branch_conflict,
    output pc_state_t     state_dbg
);

    pc_state_t    state;
    pc_sel_t      sel;
    logic [D-1:0] pc_next;
    logic         start_accept;
    logic         running;

    // The LUT is addressed straight from the instruction field, no register.
    assign lut_addr      = jump_idx[2:0];
    assign lut_third_bit = jump_idx[3];

    assign running      = (state == RUN);
    assign start_accept = start && ((state == IDLE) || (state == DONE));
    assign busy         = running;
    assign done         = (state == DONE);
    assign state_dbg    = state;

    // Next-PC priority: halt/stall hold, then absolute jump, relative, increment.
    always_comb begin
        sel     = SEL_INC;
        pc_next = prog_ctr;
        if (halt || stall) begin
            sel = SEL_HOLD;
        end else if (abs_jump) begin
            sel = SEL_ABS;
        end else if (rel_branch) begin
            sel = SEL_REL;
        end
        case (sel)
            SEL_HOLD: pc_next = prog_ctr;
            SEL_ABS:  pc_next = lut_target;
            SEL_REL:  pc_next = prog_ctr + rel_offset;
            SEL_INC:  pc_next = prog_ctr + D'(1);
            default:  pc_next = prog_ctr;
        endcase
    end

    // Sequencer state, program counter and conflict flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state           <= IDLE;
            prog_ctr        <= '0;
            branch_conflict <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state           <= RUN;
                        prog_ctr        <= start_addr;
                        branch_conflict <= 1'b0;
                    end
                end
                RUN: begin
                    prog_ctr        <= pc_next;
                    branch_conflict <= abs_jump && rel_branch;
                    if (halt) begin
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    pc_sat_counter #(
        .CW(CW)
    ) u_cycle_counter (
        .clk   (Clk),
        .reset (Reset),
        .clear (start_accept),
        .en    (running),
        .count (cycle_count)
    );

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Program-counter and fetch-sequencing stage that consumes the branch-target lookup table.
- Holds the program counter and sequences instruction fetch.
- Drives the 4-bit jump index to the target LUT and takes back its D-bit absolute target.
- Selects the next PC each cycle from: halt, stall, absolute jump, relative branch, or increment.
- Provides a start/done handshake with the testbench/top level and a run-cycle counter for performance checks.

Parameters:
D, 12, program counter / instruction-address width (matches LUT target width)
CW, 16, cycle counter width

Ports:
Clk  in  1  system clock, all state on rising edge
Reset  in  1  synchronous, active-high reset
start  in  1  begin execution; sampled only in IDLE and DONE
start_addr  in  D  first PC of the program
stall  in  1  hold PC this cycle
halt  in  1  decoded instruction is halt/done
abs_jump  in  1  taken absolute jump via LUT
jump_idx  in  4  LUT selector from instruction, {thirdBit, addr}
rel_branch  in  1  taken relative branch
rel_offset  in  D  signed two's-complement offset
lut_addr  out  3  to LUT addr, = jump_idx[2:0], combinational
lut_third_bit  out  1  to LUT thirdBit, = jump_idx[3], combinational
lut_target  in  D  absolute target returned by LUT (combinational path)
prog_ctr  out  D  current fetch address
busy  out  1  high in RUN
done  out  1  high in DONE
cycle_count  out  CW  RUN cycles of current/last program, saturating
branch_conflict  out  1  registered, abs_jump and rel_branch both high in prior RUN cycle

Behaviour:
- Reset (any state, any cycle, including mid-RUN):
  - prog_ctr=0, state=IDLE, busy=0, done=0, cycle_count=0, branch_conflict=0.
  - Reset overrides start.
- States: IDLE, RUN, DONE. busy and done are decoded from state and are registered-equivalent.
- IDLE:
  - start=1 -> next cycle: prog_ctr=start_addr, cycle_count=0, state=RUN.
  - Otherwise hold all values.
- RUN, next-PC priority (highest first):
  1. halt -> PC holds, state=DONE.
  2. stall -> PC holds.
  3. abs_jump -> PC=lut_target.
  4. rel_branch -> PC=prog_ctr+rel_offset.
  5. else -> PC=prog_ctr+1.
- Arithmetic:
  - All PC arithmetic is modulo 2^D. 4095+1 wraps to 0; 2+(-5) gives 4093.
  - rel_offset is sign-interpreted; the addition uses D bits only.
- halt with stall in the same cycle: halt wins, DONE entered.
- Jump index outside the LUT's populated range (10..15):
  - LUT returns 0 and PC becomes 0.
  - This is legal; no error is flagged.
- abs_jump and rel_branch in the same cycle:
  - abs_jump wins.
  - branch_conflict=1 in the following cycle.
  - branch_conflict clears on the next RUN cycle without conflict, and on start.
- lut_addr/lut_third_bit track jump_idx in every state. No added latency: the LUT path is combinational within one cycle.
- start while in RUN: ignored.
- cycle_count:
  - Increments by 1 on every RUN clock edge, including stalled cycles and the halt cycle.
  - Saturates at 2^CW-1.
  - Frozen in DONE and IDLE.
- DONE:
  - done stays high and prog_ctr/cycle_count hold until start.
  - start in DONE -> restart exactly as from IDLE (prog_ctr=start_addr, cycle_count=0, done=0 next cycle).

Decomposition:
- Package pc_pkg:
  - state enum {IDLE, RUN, DONE}.
  - PC_W=12 and CNT_W=16 defaults.
  - Next-PC select enum {SEL_HOLD, SEL_ABS, SEL_REL, SEL_INC}.
- Sub-module pc_sat_counter: CW-bit saturating counter with clear and enable, used for cycle_count.
- Next-PC mux and state machine stay in pc_fetch_ctrl.

Test Plan:
- Reset mid-RUN at prog_ctr=37 -> next cycle prog_ctr=0, busy=0, done=0, cycle_count=0.
- start, start_addr=0, 5 plain cycles -> prog_ctr 0,1,2,3,4,5; cycle_count=5.
- abs_jump with jump_idx=4'b0000 -> lut_addr=0, lut_third_bit=0, prog_ctr=53 next cycle. jump_idx=4'b1001 -> 175. jump_idx=4'b1100 -> 0.
- prog_ctr=2, rel_branch, rel_offset=12'hFFB (-5) -> 4093. prog_ctr=4095 increment -> 0.
- Same cycle abs_jump (idx 7) and rel_branch (+3) at PC=10 -> PC=400, branch_conflict=1 next cycle, cleared after one clean cycle.
- Sequence: stall 3 cycles, then halt+stall -> PC frozen throughout, DONE entered, cycle_count counts all 4. Then start with start_addr=128 -> RUN at 128, done=0.
